// File: rtl/outport_uart_tx.sv
// outport_uart_tx
//   Serial observer for the mini CPU output port. Every word the CPU writes
//   through the OutPort strobe is queued in a small FIFO. The queued words are
//   sent on a UART line, WORD_BYTES bytes per word, with byte 0 (bits [7:0])
//   sent first.
//
//   Frame format:
//     - default build: 8N1 (start, 8 data bits LSB first, stop)
//     - OUTPORT_TX_PARITY_EN defined: 8E1. An even parity bit is inserted
//       between the last data bit and the stop bit. The port list is identical
//       in both builds.
//
//   Handshake: out_wr is a one-cycle write strobe with no ready/back-pressure.
//   The word on out_data is accepted when the FIFO has room at that edge.
//   Room exists when count < FIFO_DEPTH, or when the FIFO is full but the
//   transmitter pops a word at the same edge. Any other write is dropped and
//   sets the sticky overflow flag. The flag is held until Reset.
//
//   The FSM state is held in the internal signal 'state' so that checkers can
//   observe it:
//     IDLE -> START -> DATA -> (PAR) -> STOP

`timescale 1ns/1ps

module outport_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int WORD_BYTES   = 1
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [31:0] out_data,
  input  logic        out_wr,
  output logic        tx,
  output logic        busy,
  output logic        empty,
  output logic        full,
  output logic        overflow
);

  // Derived widths
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef OUTPORT_TX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          ovf_r;

  // Transmitter
  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;   // cycles spent in the current serial bit
  logic [2:0]    bit_idx;   // data bit being sent, 0..7
  logic [BW-1:0] byte_idx;  // byte of the current word being sent
  logic [31:0]   word;      // word being serialised
  logic          tx_r;
  logic          busy_r;

  // Combinational helpers
  logic          empty_w;
  logic          full_w;
  logic          bit_end;
  logic          last_byte;
  logic [7:0]    cur_byte;
  logic          pop;
  logic          push;

  // Status decode, byte select and FIFO push/pop qualification
  always_comb begin
    empty_w   = (count == '0);
    full_w    = (count == CNT_FULL);
    bit_end   = (clk_cnt == CNT_LAST);
    last_byte = (byte_idx == BYTE_LAST);
    cur_byte  = 8'(word >> {byte_idx, 3'b000});
    // A word is taken from the FIFO when the line is idle, or at the very end
    // of the stop bit of a word's last byte. The second case keeps
    // back-to-back words without an idle gap.
    pop  = !empty_w &&
           ((state == S_IDLE) ||
            ((state == S_STOP) && bit_end && last_byte));
    // A pop at the same edge frees a slot, so a full FIFO can still accept.
    push = out_wr && (!full_w || pop);
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (out_wr && !push) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // FIFO data storage; contents are only read while count is non-zero
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= out_data;
    end
  end

  // Frame sequencer: drives the serial line and the busy flag
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= '0;
      word     <= 32'd0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          if (!empty_w) begin
            word     <= mem[rd_ptr];
            byte_idx <= '0;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            state    <= S_START;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            tx_r    <= cur_byte[0];
            state   <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef OUTPORT_TX_PARITY_EN
              tx_r  <= ^cur_byte;
              state <= S_PAR;
`else
              tx_r  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_r    <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef OUTPORT_TX_PARITY_EN
        S_PAR: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx_r    <= 1'b1;
            state   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (!last_byte) begin
              // Next byte of the same word
              byte_idx <= byte_idx + 1'b1;
              tx_r     <= 1'b0;
              state    <= S_START;
            end else if (!empty_w) begin
              // Next word follows immediately; busy stays high
              word     <= mem[rd_ptr];
              byte_idx <= '0;
              tx_r     <= 1'b0;
              state    <= S_START;
            end else begin
              tx_r   <= 1'b1;
              busy_r <= 1'b0;
              state  <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          clk_cnt <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    tx       = tx_r;
    busy     = busy_r;
    empty    = empty_w;
    full     = full_w;
    overflow = ovf_r;
  end

endmodule

// File: tb/tb_outport_uart_tx.sv
// tb_outport_uart_tx
//   Two instances of outport_uart_tx are driven side by side. Both use
//   CLKS_PER_BIT=4 and FIFO_DEPTH=4.
//     - u_dut_a: WORD_BYTES=1
//     - u_dut_b: WORD_BYTES=4
//   A line-level model predicts every output on every cycle. A queued word
//   expands into a list of line levels, and the model steps through that list
//   one level per clock. Directed tests add literal expectations on decoded
//   frames.

`timescale 1ns/1ps

module tb_outport_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OUTPORT_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PARITY     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PARITY     = 1'b0;
`endif
  localparam int FC = FRAME_BITS * CPB;  // cycles per byte frame

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic Reset;
  always #5 clock = ~clock;

  logic        wr_a, wr_b;
  logic [31:0] data_a, data_b;
  logic        tx_a, busy_a, empty_a, full_a, ovf_a;
  logic        tx_b, busy_b, empty_b, full_b, ovf_b;

  outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .WORD_BYTES(1)) u_dut_a (
    .clock(clock), .Reset(Reset), .out_data(data_a), .out_wr(wr_a),
    .tx(tx_a), .busy(busy_a), .empty(empty_a), .full(full_a), .overflow(ovf_a)
  );

  outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .WORD_BYTES(4)) u_dut_b (
    .clock(clock), .Reset(Reset), .out_data(data_b), .out_wr(wr_b),
    .tx(tx_b), .busy(busy_b), .empty(empty_b), .full(full_b), .overflow(ovf_b)
  );

  int tests_run = 0;
  int failed    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  logic [31:0] m_word_a = 32'd0;
  logic [31:0] m_word_b = 32'd0;
  int          m_pos_a = 0, m_len_a = 0, m_pos_b = 0, m_len_b = 0;
  logic        m_ovf_a = 1'b0, m_ovf_b = 1'b0;
  logic        model_ready = 1'b0;

  // Line level at position pos of the level list generated for word w
  function automatic logic level_at(input logic [31:0] w, input int pos);
    int         byte_no;
    int         bit_no;
    logic [7:0] b;
    byte_no = pos / FC;
    bit_no  = (pos % FC) / CPB;
    b       = 8'(w >> (8 * byte_no));
    if (bit_no == 0) return 1'b0;
    if (bit_no <= 8) return b[bit_no - 1];
    if (PARITY && bit_no == 9) return ^b;
    return 1'b1;
  endfunction

  initial begin : model_and_compare
    logic exp_tx;
    forever begin
      @(posedge clock);
      if (!Reset) begin
        exp_q_a.delete(); m_pos_a = 0; m_len_a = 0; m_ovf_a = 1'b0;
        exp_q_b.delete(); m_pos_b = 0; m_len_b = 0; m_ovf_b = 1'b0;
      end else begin
        if (m_pos_a < m_len_a) m_pos_a++;
        if (m_pos_a >= m_len_a && exp_q_a.size() > 0) begin
          m_word_a = exp_q_a.pop_front(); m_pos_a = 0; m_len_a = 1 * FC;
        end
        if (wr_a) begin
          if (exp_q_a.size() < DEPTH) exp_q_a.push_back(data_a);
          else m_ovf_a = 1'b1;
        end
        if (m_pos_b < m_len_b) m_pos_b++;
        if (m_pos_b >= m_len_b && exp_q_b.size() > 0) begin
          m_word_b = exp_q_b.pop_front(); m_pos_b = 0; m_len_b = 4 * FC;
        end
        if (wr_b) begin
          if (exp_q_b.size() < DEPTH) exp_q_b.push_back(data_b);
          else m_ovf_b = 1'b1;
        end
      end
      model_ready = 1'b1;
      @(negedge clock);
      if (model_ready) begin
        exp_tx = (m_pos_a < m_len_a) ? level_at(m_word_a, m_pos_a) : 1'b1;
        chk("a_tx", 32'(tx_a), 32'(exp_tx));
        chk("a_busy", 32'(busy_a), 32'(m_pos_a < m_len_a));
        chk("a_empty", 32'(empty_a), 32'(exp_q_a.size() == 0));
        chk("a_full", 32'(full_a), 32'(exp_q_a.size() == DEPTH));
        chk("a_overflow", 32'(ovf_a), 32'(m_ovf_a));
        exp_tx = (m_pos_b < m_len_b) ? level_at(m_word_b, m_pos_b) : 1'b1;
        chk("b_tx", 32'(tx_b), 32'(exp_tx));
        chk("b_busy", 32'(busy_b), 32'(m_pos_b < m_len_b));
        chk("b_empty", 32'(empty_b), 32'(exp_q_b.size() == 0));
        chk("b_full", 32'(full_b), 32'(exp_q_b.size() == DEPTH));
        chk("b_overflow", 32'(ovf_b), 32'(m_ovf_b));
      end
    end
  end

  // ---------------- driver / capture tasks ----------------
  logic samp [0:1023];

  task automatic write_word(input int which, input logic [31:0] d);
    @(negedge clock);
    if (which == 0) begin wr_a = 1'b1; data_a = d; end
    else begin wr_b = 1'b1; data_b = d; end
    @(negedge clock);
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  // Records tx for every busy cycle until busy falls again
  task automatic capture(input int which, input int max_cyc, output int nbusy, output int full_rises);
    logic seen, prev_full, b, f, t;
    int   c;
    nbusy = 0; full_rises = 0; seen = 1'b0; prev_full = 1'b0;
    for (c = 0; c < max_cyc; c++) begin
      b = (which == 0) ? busy_a : busy_b;
      f = (which == 0) ? full_a : full_b;
      t = (which == 0) ? tx_a : tx_b;
      if (f && !prev_full) full_rises++;
      prev_full = f;
      if (b) begin
        seen = 1'b1;
        if (nbusy < 1024) samp[nbusy] = t;
        nbusy++;
      end else if (seen) begin
        break;
      end
      @(negedge clock);
    end
    tests_run++;
    if (c >= max_cyc) begin
      failed++;
      $display("FAIL capture_timeout: busy still pending after %0d cycles", max_cyc);
    end
  endtask

  function automatic logic [7:0] decode(input int frame);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = samp[frame * FC + CPB * (b + 1) + CPB / 2];
    return v;
  endfunction

  // ---------------- directed tests ----------------
  initial begin : main
    int          nb, fr, cnt;
    logic [10:0] exp_line;
    logic [7:0]  exp3 [5];
    logic [7:0]  exp4 [4];
    Reset = 1'b0; wr_a = 1'b0; wr_b = 1'b0; data_a = 32'd0; data_b = 32'd0;
    repeat (2) @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);

    // Reset state
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_overflow", 32'(ovf_a), 32'd0);

    // Single byte 0xA5
    write_word(0, 32'h000000A5);
    capture(0, 200, nb, fr);
    chk("a5_busy_cycles", 32'(nb), 32'(FC));
`ifdef OUTPORT_TX_PARITY_EN
    exp_line = 11'b1_0_10100101_0;
`else
    exp_line = 11'b1_1_10100101_0;
`endif
    for (int b = 0; b < FRAME_BITS; b++) chk("a5_line_bit", 32'(samp[b * CPB + CPB / 2]), 32'(exp_line[b]));
    chk("a5_empty_after", 32'(empty_a), 32'd1);

    // Six writes on consecutive cycles: five sent back-to-back, sixth dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clock);
          wr_a = 1'b1;
          data_a = 32'(32'h11 * (i + 1));
        end
        @(negedge clock);
        wr_a = 1'b0;
      end
      capture(0, 600, nb, fr);
    join
    exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    chk("b2b_busy_cycles", 32'(nb), 32'(5 * FC));
    chk("b2b_full_rises", 32'(fr), 32'd1);
    chk("b2b_overflow", 32'(ovf_a), 32'd1);
    for (int j = 0; j < 5; j++) chk("b2b_byte", 32'(decode(j)), 32'(exp3[j]));

    // Four-byte word on the WORD_BYTES=4 instance
    write_word(1, 32'hDEADBEEF);
    capture(1, 400, nb, fr);
    exp4 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk("w4_busy_cycles", 32'(nb), 32'(4 * FC));
    for (int j = 0; j < 4; j++) chk("w4_byte", 32'(decode(j)), 32'(exp4[j]));

    // 0x07: odd number of ones, parity bit is 1 (stop bit without parity)
    write_word(0, 32'h00000007);
    capture(0, 200, nb, fr);
    chk("p07_busy_cycles", 32'(nb), 32'(FC));
    chk("p07_byte", 32'(decode(0)), 32'h07);
    chk("p07_bit9", 32'(samp[9 * CPB + CPB / 2]), 32'd1);

    // Reset in the middle of the data bits of 0xFF with another word queued
    write_word(0, 32'h000000FF);
    write_word(0, 32'h00000012);
    repeat (12) @(negedge clock);
    chk("mid_busy_before", 32'(busy_a), 32'd1);
    chk("mid_empty_before", 32'(empty_a), 32'd0);
    Reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_tx", 32'(tx_a), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_empty", 32'(empty_a), 32'd1);
    chk("mid_rst_overflow", 32'(ovf_a), 32'd0);
    Reset = 1'b1;
    cnt = 0;
    repeat (60) begin
      @(negedge clock);
      if (busy_a || !tx_a) cnt++;
    end
    chk("mid_no_resume", 32'(cnt), 32'd0);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
